sysbus_arbiter: RTL and testbench

Two-port arbiter sharing the single Sysbus memory interface between the instruction-fetch port (`i_*`) and the data/load-store port (`d_*`) of the core. Grants whole transactions (request beat plus 8 response or write-data beats), round-robins between ports when both request, and steers acks and response beats only to the owner. Sits between the core's fetch/memory stages and the top-level `bus_*` pins.

---
 rtl/sysbus_arbiter.sv | 141 ++++++++++++++
 tb/tb_sysbus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the single Sysbus memory port between instruction fetch (i_*) and
// load/store (d_*), granting whole transactions and alternating ownership on ties.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  // fetch port
  input  logic                      i_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  input  logic                      i_respack,
  output logic                      i_reqack,
  output logic                      i_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] i_resp,
  output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
  // load/store port
  input  logic                      d_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  input  logic                      d_respack,
  output logic                      d_reqack,
  output logic                      d_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] d_resp,
  output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
  // memory side
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respack,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int BEAT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t              state;
  owner_t              owner;
  owner_t              last_owner;
  logic [BEAT_W-1:0]   beat;

  logic                      own_reqcyc;
  logic                      own_respack;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      req_phase;
  logic                      resp_phase;
  logic                      req_fire;
  logic                      resp_fire;
  logic                      last_beat;
  logic                      sel_i;
  logic                      sel_d;

  assign own_reqcyc  = (owner == OWN_I) ? i_reqcyc  : d_reqcyc;
  assign own_respack = (owner == OWN_I) ? i_respack : d_respack;
  assign own_req     = (owner == OWN_I) ? i_req     : d_req;
  assign own_reqtag  = (owner == OWN_I) ? i_reqtag  : d_reqtag;

  assign req_phase  = (state == REQ) || (state == WDATA);
  assign resp_phase = (state == RESP);
  assign req_fire   = req_phase && own_reqcyc && bus_reqack;
  assign resp_fire  = resp_phase && bus_respcyc && own_respack;
  assign last_beat  = (beat == BEAT_W'(BEATS - 1));

  // Ownership is decided once in IDLE and held until the final beat, so the muxes above
  // stay stable for the whole transaction; an owner dropping reqcyc before its ack aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_D;
      beat       <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (i_reqcyc || d_reqcyc) begin
            state <= REQ;
            if (i_reqcyc && d_reqcyc)
              owner <= (last_owner == OWN_I) ? OWN_D : OWN_I;
            else
              owner <= i_reqcyc ? OWN_I : OWN_D;
          end
        end
        REQ: begin
          if (req_fire) begin
            state <= own_reqtag[BUS_TAG_WIDTH-1] ? RESP : WDATA;
            beat  <= '0;
          end else if (!own_reqcyc) begin
            state <= IDLE;
          end
        end
        WDATA: begin
          if (req_fire) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              state      <= IDLE;
              last_owner <= owner;
            end
          end
        end
        RESP: begin
          if (resp_fire) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              state      <= IDLE;
              last_owner <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_i = (owner == OWN_I);
  assign sel_d = (owner == OWN_D);

  // Everything outward is gated by state so IDLE (including async reset) drives zeros.
  assign bus_reqcyc  = req_phase && own_reqcyc;
  assign bus_req     = req_phase ? own_req : '0;
  assign bus_reqtag  = req_phase ? own_reqtag : '0;
  assign bus_respack = resp_phase && own_respack;

  assign i_reqack  = req_phase && sel_i && bus_reqack;
  assign d_reqack  = req_phase && sel_d && bus_reqack;
  assign i_respcyc = resp_phase && sel_i && bus_respcyc;
  assign d_respcyc = resp_phase && sel_d && bus_respcyc;
  assign i_resp    = (resp_phase && sel_i) ? bus_resp    : '0;
  assign d_resp    = (resp_phase && sel_d) ? bus_resp    : '0;
  assign i_resptag = (resp_phase && sel_i) ? bus_resptag : '0;
  assign d_resptag = (resp_phase && sel_d) ? bus_resptag : '0;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: randomized transactions against a transaction-level model of
// ownership, tie-breaking and beat counting for sysbus_arbiter.
module tb_sysbus_arbiter;

  localparam int DW     = 64;
  localparam int TW     = 13;
  localparam int BEATS  = 8;
  localparam int OWN_I  = 1;
  localparam int OWN_D  = 2;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_RESP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_reqcyc = 1'b0, d_reqcyc = 1'b0;
  logic [DW-1:0] i_req = '0, d_req = '0;
  logic [TW-1:0] i_reqtag = '0, d_reqtag = '0;
  logic          i_respack = 1'b0, d_respack = 1'b0;
  logic          i_reqack, d_reqack, i_respcyc, d_respcyc;
  logic [DW-1:0] i_resp, d_resp;
  logic [TW-1:0] i_resptag, d_resptag;
  logic          bus_reqcyc, bus_respack;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack = 1'b0, bus_respcyc = 1'b0;
  logic [DW-1:0] bus_resp = '0;
  logic [TW-1:0] bus_resptag = '0;

  int checks = 0;
  int failures = 0;
  int last_owner = OWN_D;
  bit i_pend = 1'b0;
  bit d_pend = 1'b0;

  always #5 clk = ~clk;

  sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_respack(i_respack),
    .i_reqack(i_reqack), .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_respack(d_respack),
    .d_reqack(d_reqack), .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respack(bus_respack), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // own = granted port (0 = none); mode says which side of the transaction is live
  task automatic check_all(input int own, input int mode);
    logic          o_cyc, o_rack, rq, rs, gi, gd;
    logic [DW-1:0] o_req;
    logic [TW-1:0] o_tag;
    o_cyc  = (own == OWN_I) ? i_reqcyc  : d_reqcyc;
    o_rack = (own == OWN_I) ? i_respack : d_respack;
    o_req  = (own == OWN_I) ? i_req     : d_req;
    o_tag  = (own == OWN_I) ? i_reqtag  : d_reqtag;
    rq = (mode == M_REQ);
    rs = (mode == M_RESP);
    gi = (own == OWN_I);
    gd = (own == OWN_D);
    check_output("bus_reqcyc",  64'(bus_reqcyc),  64'(rq & o_cyc));
    check_output("bus_req",     bus_req,          rq ? o_req : 64'(0));
    check_output("bus_reqtag",  64'(bus_reqtag),  rq ? 64'(o_tag) : 64'(0));
    check_output("bus_respack", 64'(bus_respack), 64'(rs & o_rack));
    check_output("i_reqack",    64'(i_reqack),    64'(rq & gi & bus_reqack));
    check_output("d_reqack",    64'(d_reqack),    64'(rq & gd & bus_reqack));
    check_output("i_respcyc",   64'(i_respcyc),   64'(rs & gi & bus_respcyc));
    check_output("d_respcyc",   64'(d_respcyc),   64'(rs & gd & bus_respcyc));
    check_output("i_resp",      i_resp,           (rs & gi) ? bus_resp : 64'(0));
    check_output("d_resp",      d_resp,           (rs & gd) ? bus_resp : 64'(0));
    check_output("i_resptag",   64'(i_resptag),   (rs & gi) ? 64'(bus_resptag) : 64'(0));
    check_output("d_resptag",   64'(d_resptag),   (rs & gd) ? 64'(bus_resptag) : 64'(0));
  endtask

  task automatic new_request(input int port, input bit force_read);
    logic [TW-1:0] tag;
    tag = TW'($urandom);
    if (force_read) tag[TW-1] = 1'b1;
    if (port == OWN_I) begin
      i_reqcyc = 1'b1; i_req = {$urandom, $urandom}; i_reqtag = tag; i_pend = 1'b1;
    end else begin
      d_reqcyc = 1'b1; d_req = {$urandom, $urandom}; d_reqtag = tag; d_pend = 1'b1;
    end
  endtask

  task automatic drop_owner(input int own);
    if (own == OWN_I) begin i_reqcyc = 1'b0; i_pend = 1'b0; end
    else begin d_reqcyc = 1'b0; d_pend = 1'b0; end
  endtask

  task automatic randomize_resp_side();
    bus_respcyc = ($urandom_range(3) != 0);
    bus_resp    = {$urandom, $urandom};
    bus_resptag = TW'($urandom);
    i_respack   = ($urandom_range(3) != 0);
    d_respack   = ($urandom_range(3) != 0);
  endtask

  // One arbitration plus its whole transaction, starting in the IDLE cycle.
  task automatic apply_stimulus(input bit allow_violate);
    int own, beats, cycles, wait_ack;
    bit is_read, violate;
    bus_reqack  = $urandom_range(1);
    bus_respcyc = $urandom_range(1);
    settle();
    check_all(0, M_IDLE);
    if (i_reqcyc && d_reqcyc) own = (last_owner == OWN_I) ? OWN_D : OWN_I;
    else                      own = i_reqcyc ? OWN_I : OWN_D;
    is_read = (own == OWN_I) ? i_reqtag[TW-1] : d_reqtag[TW-1];
    violate = allow_violate && ($urandom_range(7) == 0);
    next_edge();
    bus_respcyc = 1'b0;
    wait_ack = $urandom_range(2);
    for (int k = 0; k < wait_ack; k++) begin
      bus_reqack = 1'b0;
      settle();
      check_all(own, M_REQ);
      next_edge();
    end
    if (violate) begin
      drop_owner(own);
      bus_reqack = $urandom_range(1);
      settle();
      check_all(own, M_REQ);
      next_edge();
      bus_reqack = 1'b0;
      return;
    end
    bus_reqack = 1'b1;
    settle();
    check_all(own, M_REQ);
    next_edge();
    beats = 0;
    cycles = 0;
    if (is_read) begin
      drop_owner(own);
      while (beats < BEATS && cycles < 200) begin
        randomize_resp_side();
        bus_reqack = $urandom_range(1);
        settle();
        check_all(own, M_RESP);
        if (bus_respcyc && ((own == OWN_I) ? i_respack : d_respack)) beats++;
        next_edge();
        cycles++;
      end
    end else begin
      while (beats < BEATS && cycles < 200) begin
        randomize_resp_side();
        if (own == OWN_I) begin i_reqcyc = ($urandom_range(3) != 0); i_req = {$urandom, $urandom}; end
        else              begin d_reqcyc = ($urandom_range(3) != 0); d_req = {$urandom, $urandom}; end
        bus_reqack = ($urandom_range(3) != 0);
        settle();
        check_all(own, M_REQ);
        if (bus_reqack && ((own == OWN_I) ? i_reqcyc : d_reqcyc)) beats++;
        next_edge();
        cycles++;
      end
      drop_owner(own);
    end
    check_output("beat_count", 64'(beats), 64'(BEATS));
    bus_reqack = 1'b0; bus_respcyc = 1'b0; i_respack = 1'b0; d_respack = 1'b0;
    last_owner = own;
  endtask

  initial begin
    $display("[TB] sysbus_arbiter bench starting");
    reset = 1'b0;
    bus_respcyc = 1'b1;
    i_respack = 1'b1;
    repeat (2) next_edge();
    settle();
    check_all(0, M_IDLE);

    // both ports requesting as reset releases: I must win, I's transaction is a read
    new_request(OWN_I, 1'b1);
    i_reqtag = 13'h1100;
    new_request(OWN_D, 1'b0);
    bus_respcyc = 1'b0;
    i_respack = 1'b0;
    next_edge();
    reset = 1'b1;
    apply_stimulus(1'b0);
    // D was held through I's read and is now granted after the IDLE gap
    apply_stimulus(1'b0);

    for (int t = 0; t < 60; t++) begin
      if (!i_pend && $urandom_range(1) == 1) new_request(OWN_I, 1'b0);
      if (!d_pend && $urandom_range(1) == 1) new_request(OWN_D, 1'b0);
      if (!i_pend && !d_pend) new_request(($urandom_range(1) == 1) ? OWN_I : OWN_D, 1'b0);
      apply_stimulus(1'b1);
    end

    // reset in the middle of an I read, after four response beats
    if (d_pend) drop_owner(OWN_D);
    if (!i_pend) new_request(OWN_I, 1'b1);
    i_reqtag[TW-1] = 1'b1;
    settle();
    check_all(0, M_IDLE);
    next_edge();
    bus_reqack = 1'b1;
    settle();
    check_all(OWN_I, M_REQ);
    next_edge();
    drop_owner(OWN_I);
    bus_reqack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus_respcyc = 1'b1; i_respack = 1'b1; bus_resp = 64'(b); bus_resptag = 13'h1100;
      settle();
      check_all(OWN_I, M_RESP);
      next_edge();
    end
    bus_respcyc = 1'b1;
    settle();
    reset = 1'b0;
    #1;
    check_all(0, M_IDLE);
    next_edge();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_all(0, M_IDLE);
      next_edge();
    end
    bus_respcyc = 1'b0;
    i_respack = 1'b0;
    last_owner = OWN_D;
    new_request(OWN_I, 1'b0);
    new_request(OWN_D, 1'b0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
